// File: rtl/arm_defs.sv
// Shared ARM decode definitions: execute commands, instruction modes, condition codes.
package arm_defs;

    localparam int REG_COUNT_DEF = 16;
    localparam int REG_AW_DEF    = $clog2(REG_COUNT_DEF);

    typedef enum logic [3:0] {
        EXE_CMD_NOP = 4'b0000,
        EXE_CMD_MOV = 4'b0001,
        EXE_CMD_ADD = 4'b0010,
        EXE_CMD_ADC = 4'b0011,
        EXE_CMD_SUB = 4'b0100,
        EXE_CMD_SBC = 4'b0101,
        EXE_CMD_AND = 4'b0110,
        EXE_CMD_ORR = 4'b0111,
        EXE_CMD_EOR = 4'b1000,
        EXE_CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10
    } mode_e;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
        OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
        OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111
    } dp_op_e;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb_en;
        logic branch;
        logic s;
        logic imm;
    } ctl_t;

    // nzcv = {N, Z, C, V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_reg_file.sv
// Architectural register file: reset to index values, one write port, two reads with WB write-through.
module id_reg_file import arm_defs::*; #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = REG_COUNT_DEF,
    localparam int REG_AW   = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = (wr_en && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
        rd_data2 = (wr_en && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage with RAW stall and registered ID/EX boundary.
// FORWARDING_EN: when defined, only load-use hazards against EXE stall.
module id_issue_stage import arm_defs::*; #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_COUNT = REG_COUNT_DEF,
    parameter int EXE_CMD_W = 4,
    localparam int REG_AW   = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    pc_in,
    input  logic [31:0]          instr_in,
    input  logic                 instr_valid,
    input  logic                 flush,
    input  logic [3:0]           status_in,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_read,
    input  logic [REG_AW-1:0]    exe_dest,
    input  logic                 mem_wb_en,
    input  logic [REG_AW-1:0]    mem_dest,
    input  logic                 wb_en,
    input  logic [REG_AW-1:0]    wb_dest,
    input  logic [DATA_W-1:0]    wb_value,
    output logic                 stall_out,
    output logic                 ex_valid,
    output logic [ADDR_W-1:0]    ex_pc,
    output logic [EXE_CMD_W-1:0] ex_cmd,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_wb_en,
    output logic                 ex_branch,
    output logic                 ex_s,
    output logic                 ex_imm,
    output logic [DATA_W-1:0]    ex_val_rn,
    output logic [DATA_W-1:0]    ex_val_rm,
    output logic [REG_AW-1:0]    ex_dest,
    output logic [REG_AW-1:0]    ex_src1,
    output logic [REG_AW-1:0]    ex_src2,
    output logic [11:0]          ex_shift_operand,
    output logic [23:0]          ex_simm24
);

    logic [1:0]        mode;
    logic [3:0]        op;
    logic              s_bit, i_bit, is_dp, is_str;
    logic              src1_used, src2_used, exe_hit, mem_hit, hazard, cond_ok, unused_inputs;
    logic [REG_AW-1:0] src1, src2;
    logic [DATA_W-1:0] val_rn, val_rm;
    exe_cmd_e          cmd;
    ctl_t              ctl;

    assign mode   = instr_in[27:26];
    assign op     = instr_in[24:21];
    assign s_bit  = instr_in[20];
    assign i_bit  = instr_in[25];
    assign is_dp  = (mode == MODE_DP);
    assign is_str = (mode == MODE_MEM) && !s_bit;

    always_comb begin
        cmd = EXE_CMD_NOP;
        ctl = '0;
        case (mode)
            MODE_DP: begin
                ctl.imm   = i_bit;
                ctl.wb_en = 1'b1;
                ctl.s     = s_bit;
                case (op)
                    OP_MOV:  cmd = EXE_CMD_MOV;
                    OP_MVN:  cmd = EXE_CMD_MVN;
                    OP_ADD:  cmd = EXE_CMD_ADD;
                    OP_ADC:  cmd = EXE_CMD_ADC;
                    OP_SUB:  cmd = EXE_CMD_SUB;
                    OP_SBC:  cmd = EXE_CMD_SBC;
                    OP_AND:  cmd = EXE_CMD_AND;
                    OP_ORR:  cmd = EXE_CMD_ORR;
                    OP_EOR:  cmd = EXE_CMD_EOR;
                    OP_CMP: begin
                        cmd       = EXE_CMD_SUB;
                        ctl.wb_en = 1'b0;
                        ctl.s     = 1'b1;
                    end
                    OP_TST: begin
                        cmd       = EXE_CMD_AND;
                        ctl.wb_en = 1'b0;
                        ctl.s     = 1'b1;
                    end
                    default: ctl = '0;
                endcase
            end
            MODE_MEM: begin
                cmd           = EXE_CMD_ADD;
                ctl.imm       = 1'b1;
                ctl.mem_read  = s_bit;
                ctl.wb_en     = s_bit;
                ctl.mem_write = !s_bit;
            end
            MODE_BR: ctl.branch = 1'b1;
            default: ctl = '0;
        endcase
    end

    assign src1      = REG_AW'(instr_in[19:16]);
    assign src2      = is_str ? REG_AW'(instr_in[15:12]) : REG_AW'(instr_in[3:0]);
    assign src1_used = !((mode == MODE_BR) || (is_dp && (op == OP_MOV || op == OP_MVN)));
    assign src2_used = (is_dp && !i_bit) || is_str;
    assign exe_hit   = (src1_used && exe_dest == src1) || (src2_used && exe_dest == src2);
    assign mem_hit   = (src1_used && mem_dest == src1) || (src2_used && mem_dest == src2);
    assign cond_ok   = cond_pass(instr_in[31:28], status_in);

`ifdef FORWARDING_EN
    assign hazard        = instr_valid && exe_wb_en && exe_mem_read && exe_hit;
    assign unused_inputs = mem_wb_en ^ mem_hit;
`else
    assign hazard        = instr_valid && ((exe_wb_en && exe_hit) || (mem_wb_en && mem_hit));
    assign unused_inputs = exe_mem_read;
`endif

    assign stall_out = hazard && !flush;

    id_reg_file #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wb_en),
        .wr_addr  (wb_dest),
        .wr_data  (wb_value),
        .rd_addr1 (src1),
        .rd_data1 (val_rn),
        .rd_addr2 (src2),
        .rd_data2 (val_rm)
    );

    // Data fields load every cycle; only valid and control bits are gated for bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_pc            <= '0;
            ex_cmd           <= '0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_wb_en         <= 1'b0;
            ex_branch        <= 1'b0;
            ex_s             <= 1'b0;
            ex_imm           <= 1'b0;
            ex_val_rn        <= '0;
            ex_val_rm        <= '0;
            ex_dest          <= '0;
            ex_src1          <= '0;
            ex_src2          <= '0;
            ex_shift_operand <= '0;
            ex_simm24        <= '0;
        end else begin
            ex_pc            <= pc_in;
            ex_val_rn        <= val_rn;
            ex_val_rm        <= val_rm;
            ex_dest          <= REG_AW'(instr_in[15:12]);
            ex_src1          <= src1;
            ex_src2          <= src2;
            ex_shift_operand <= instr_in[11:0];
            ex_simm24        <= instr_in[23:0];
            if (flush || hazard || !instr_valid || !cond_ok) begin
                ex_valid     <= 1'b0;
                ex_cmd       <= '0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_wb_en     <= 1'b0;
                ex_branch    <= 1'b0;
                ex_s         <= 1'b0;
                ex_imm       <= 1'b0;
            end else begin
                ex_valid     <= 1'b1;
                ex_cmd       <= EXE_CMD_W'(cmd);
                ex_mem_read  <= ctl.mem_read;
                ex_mem_write <= ctl.mem_write;
                ex_wb_en     <= ctl.wb_en;
                ex_branch    <= ctl.branch;
                ex_s         <= ctl.s;
                ex_imm       <= ctl.imm;
            end
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: vector table with scoreboard plus multi-cycle sequences.
module tb_id_issue_stage;

    localparam int DATA_W = 32, ADDR_W = 32, REG_COUNT = 16, EXE_CMD_W = 4, REG_AW = 4;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [ADDR_W-1:0] pc_in;
    logic [31:0] instr_in;
    logic instr_valid, flush;
    logic [3:0] status_in;
    logic exe_wb_en, exe_mem_read, mem_wb_en, wb_en;
    logic [REG_AW-1:0] exe_dest, mem_dest, wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic stall_out, ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic [EXE_CMD_W-1:0] ex_cmd;
    logic ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s, ex_imm;
    logic [DATA_W-1:0] ex_val_rn, ex_val_rm;
    logic [REG_AW-1:0] ex_dest, ex_src1, ex_src2;
    logic [11:0] ex_shift_operand;
    logic [23:0] ex_simm24;

    id_issue_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_COUNT(REG_COUNT), .EXE_CMD_W(EXE_CMD_W)
    ) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .instr_valid(instr_valid),
        .flush(flush), .status_in(status_in), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_value(wb_value), .stall_out(stall_out), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_cmd(ex_cmd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_wb_en(ex_wb_en), .ex_branch(ex_branch), .ex_s(ex_s), .ex_imm(ex_imm),
        .ex_val_rn(ex_val_rn), .ex_val_rm(ex_val_rm), .ex_dest(ex_dest), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .ex_shift_operand(ex_shift_operand), .ex_simm24(ex_simm24)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  status;
        logic        valid, flush, exe_wb, exe_mr, mem_wb, wb;
        logic [3:0]  exe_dest, mem_dest, wb_dest;
        logic [31:0] wb_value;
        logic        stall, issue, full;
        logic [3:0]  cmd;
        logic [5:0]  ctl;          // {mem_read, mem_write, wb_en, branch, s, imm}
        logic [3:0]  src1, src2, dest;
    } vec_t;

    typedef struct {
        string       name;
        logic        issue, full;
        logic [3:0]  cmd;
        logic [5:0]  ctl;
        logic [3:0]  src1, src2, dest;
        logic [31:0] val_rn, val_rm, pc, instr;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    logic [31:0] model_rf [16];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] instr, input logic [3:0] st,
                                input logic [3:0] cmd, input logic [5:0] ctl,
                                input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d);
        vec_t v;
        v.name = n; v.instr = instr; v.status = st;
        v.valid = 1'b1; v.flush = 1'b0; v.exe_wb = 1'b0; v.exe_mr = 1'b0; v.mem_wb = 1'b0; v.wb = 1'b0;
        v.exe_dest = 4'd0; v.mem_dest = 4'd0; v.wb_dest = 4'd0; v.wb_value = 32'd0;
        v.stall = 1'b0; v.issue = 1'b1; v.full = 1'b1;
        v.cmd = cmd; v.ctl = ctl; v.src1 = s1; v.src2 = s2; v.dest = d;
        return v;
    endfunction

    task automatic clear_inputs();
        instr_valid = 1'b0; flush = 1'b0; status_in = 4'h0; instr_in = 32'h0;
        exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_dest = '0;
        mem_wb_en = 1'b0; mem_dest = '0; wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: actual=empty required=entry");
            return;
        end
        e = sb.pop_front();
        check({e.name, ".ex_valid"}, 64'(ex_valid), 64'(e.issue));
        if (!e.issue || e.full)
            check({e.name, ".ctl"}, 64'({ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s, ex_imm}),
                  64'(e.issue ? e.ctl : 6'b0));
        else
            check({e.name, ".branch"}, 64'(ex_branch), 64'(e.ctl[2]));
        if (e.issue) begin
            check({e.name, ".pc"}, 64'(ex_pc), 64'(e.pc));
            if (e.full) begin
                check({e.name, ".cmd"}, 64'(ex_cmd), 64'(e.cmd));
                check({e.name, ".srcs_dest"}, 64'({ex_src1, ex_src2, ex_dest}), 64'({e.src1, e.src2, e.dest}));
                check({e.name, ".val_rn"}, 64'(ex_val_rn), 64'(e.val_rn));
                check({e.name, ".val_rm"}, 64'(ex_val_rm), 64'(e.val_rm));
                check({e.name, ".shift"}, 64'(ex_shift_operand), 64'(e.instr[11:0]));
            end else begin
                check({e.name, ".simm24"}, 64'(ex_simm24), 64'(e.instr[23:0]));
            end
        end
    endtask

    task automatic apply(input vec_t v, input logic [31:0] pc);
        exp_t e;
        @(negedge clk);
        instr_in = v.instr; status_in = v.status; instr_valid = v.valid; flush = v.flush;
        exe_wb_en = v.exe_wb; exe_mem_read = v.exe_mr; exe_dest = v.exe_dest;
        mem_wb_en = v.mem_wb; mem_dest = v.mem_dest;
        wb_en = v.wb; wb_dest = v.wb_dest; wb_value = v.wb_value; pc_in = pc;
        #1;
        check({v.name, ".stall_out"}, 64'(stall_out), 64'(v.stall));
        e.name = v.name; e.issue = v.issue; e.full = v.full; e.cmd = v.cmd; e.ctl = v.ctl;
        e.src1 = v.src1; e.src2 = v.src2; e.dest = v.dest; e.pc = pc; e.instr = v.instr;
        e.val_rn = (v.wb && v.wb_dest == v.src1) ? v.wb_value : model_rf[v.src1];
        e.val_rm = (v.wb && v.wb_dest == v.src2) ? v.wb_value : model_rf[v.src2];
        sb.push_back(e);
        @(posedge clk);
        if (v.wb) model_rf[v.wb_dest] = v.wb_value;
        #1;
        compare_head();
    endtask

    initial begin
        vec_t v;
        int   stalls;
        bit   issued;

        for (int i = 0; i < 16; i++) model_rf[i] = 32'(i);

        v = mk("read_r5", 32'hE0851002, 4'h0, 4'b0010, 6'b001000, 4'd5, 4'd2, 4'd1);
        tbl.push_back(v);
        v = mk("add_wb_bypass", 32'hE0831002, 4'h0, 4'b0010, 6'b001000, 4'd3, 4'd2, 4'd1);
        v.wb = 1'b1; v.wb_dest = 4'd3; v.wb_value = 32'hDEADBEEF; tbl.push_back(v);
        v = mk("sub_exe_raw", 32'hE2446001, 4'h0, 4'b0100, 6'b001001, 4'd4, 4'd1, 4'd6);
        v.exe_wb = 1'b1; v.exe_dest = 4'd4; v.stall = !FWD; v.issue = FWD; tbl.push_back(v);
        v = mk("sub_mem_raw", 32'hE2446001, 4'h0, 4'b0100, 6'b001001, 4'd4, 4'd1, 4'd6);
        v.mem_wb = 1'b1; v.mem_dest = 4'd4; v.stall = !FWD; v.issue = FWD; tbl.push_back(v);
        v = mk("sub_imm_src2_unused", 32'hE2446001, 4'h0, 4'b0100, 6'b001001, 4'd4, 4'd1, 4'd6);
        v.exe_wb = 1'b1; v.exe_dest = 4'd1; tbl.push_back(v);
        v = mk("mov_rn_unused", 32'hE3A07005, 4'h0, 4'b0001, 6'b001001, 4'd0, 4'd5, 4'd7);
        v.exe_wb = 1'b1; v.exe_dest = 4'd0; tbl.push_back(v);
        v = mk("cmp", 32'hE1510002, 4'h5, 4'b0100, 6'b000010, 4'd1, 4'd2, 4'd0);
        tbl.push_back(v);
        v = mk("ldr", 32'hE5912004, 4'h0, 4'b0010, 6'b101001, 4'd1, 4'd4, 4'd2);
        v.exe_wb = 1'b1; v.exe_dest = 4'd4; tbl.push_back(v);
        v = mk("str_rd_raw", 32'hE5813000, 4'h0, 4'b0010, 6'b010001, 4'd1, 4'd3, 4'd3);
        v.exe_wb = 1'b1; v.exe_dest = 4'd3; v.stall = !FWD; v.issue = FWD; tbl.push_back(v);
        v = mk("load_use", 32'hE0215002, 4'h0, 4'b1000, 6'b001000, 4'd1, 4'd2, 4'd5);
        v.exe_wb = 1'b1; v.exe_mr = 1'b1; v.exe_dest = 4'd2; v.stall = 1'b1; v.issue = 1'b0; tbl.push_back(v);
        v = mk("beq_z0", 32'h0A000010, 4'b0000, 4'b0000, 6'b000100, 4'd0, 4'd0, 4'd0);
        v.issue = 1'b0; v.full = 1'b0; tbl.push_back(v);
        v = mk("beq_z1", 32'h0A000010, 4'b0100, 4'b0000, 6'b000100, 4'd0, 4'd0, 4'd0);
        v.full = 1'b0; tbl.push_back(v);
        v = mk("flush_over_hazard", 32'hE0215002, 4'h0, 4'b1000, 6'b001000, 4'd1, 4'd2, 4'd5);
        v.flush = 1'b1; v.exe_wb = 1'b1; v.exe_mr = 1'b1; v.exe_dest = 4'd2; v.issue = 1'b0; tbl.push_back(v);
        v = mk("invalid_no_stall", 32'hE0831002, 4'h0, 4'b0010, 6'b001000, 4'd3, 4'd2, 4'd1);
        v.valid = 1'b0; v.exe_wb = 1'b1; v.exe_mr = 1'b1; v.exe_dest = 4'd3; v.issue = 1'b0; tbl.push_back(v);
        v = mk("cond_nv", 32'hF0831002, 4'hF, 4'b0010, 6'b001000, 4'd3, 4'd2, 4'd1);
        v.issue = 1'b0; tbl.push_back(v);
        v = mk("cond_gt_pass", 32'hC0831002, 4'b1001, 4'b0010, 6'b001000, 4'd3, 4'd2, 4'd1);
        tbl.push_back(v);
        v = mk("cond_lt_pass", 32'hB0831002, 4'b1000, 4'b0010, 6'b001000, 4'd3, 4'd2, 4'd1);
        tbl.push_back(v);
        v = mk("cond_hi_fail", 32'h80831002, 4'b0110, 4'b0010, 6'b001000, 4'd3, 4'd2, 4'd1);
        v.issue = 1'b0; tbl.push_back(v);
        v = mk("eor_rm_bypass", 32'hE0215002, 4'h0, 4'b1000, 6'b001000, 4'd1, 4'd2, 4'd5);
        v.wb = 1'b1; v.wb_dest = 4'd2; v.wb_value = 32'h00001234; tbl.push_back(v);

        rst = 1'b1; pc_in = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset.ex_valid", 64'(ex_valid), 64'd0);
        check("reset.ctl", 64'({ex_mem_read, ex_mem_write, ex_wb_en, ex_branch, ex_s, ex_imm}), 64'd0);
        check("reset.data", 64'({ex_val_rn, ex_pc}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 32'h1000 + 32'(i) * 4);

        // Load-use: producer walks EXE -> MEM -> WB while ADD R1,R2,R3 waits in ID.
        stalls = 0; issued = 1'b0;
        for (int k = 0; k < 6 && !issued; k++) begin
            @(negedge clk);
            clear_inputs();
            instr_in = 32'hE0821003; instr_valid = 1'b1; pc_in = 32'h2000;
            if (k == 0) begin exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd2; end
            if (k == 1) begin mem_wb_en = 1'b1; mem_dest = 4'd2; end
            if (k == 2) begin wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hCAFE0002; end
            #1;
            if (stall_out) stalls++;
            @(posedge clk);
            if (k == 2) model_rf[2] = 32'hCAFE0002;
            #1;
            issued = ex_valid;
        end
        check("load_use_seq.issued", 64'(issued), 64'd1);
        check("load_use_seq.stall_cycles", 64'(stalls), FWD ? 64'd1 : 64'd2);
        check("load_use_seq.val_rn", 64'(ex_val_rn), 64'(model_rf[2]));

        // Reset during a stall: stall_out tracks inputs, register file returns to index values.
        @(negedge clk);
        clear_inputs();
        instr_in = 32'hE0831002; instr_valid = 1'b1; exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd3;
        rst = 1'b1;
        #1;
        check("rst_mid_stall.stall_out", 64'(stall_out), 64'd1);
        @(posedge clk); #1;
        check("rst_mid_stall.ex_valid", 64'(ex_valid), 64'd0);
        check("rst_mid_stall.ex_dest", 64'(ex_dest), 64'd0);
        @(negedge clk);
        rst = 1'b0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        for (int i = 0; i < 16; i++) model_rf[i] = 32'(i);
        #1;
        check("post_rst.stall_out", 64'(stall_out), 64'd0);
        @(posedge clk); #1;
        check("post_rst.ex_valid", 64'(ex_valid), 64'd1);
        check("post_rst.val_rn", 64'(ex_val_rn), 64'(model_rf[3]));

        check("scoreboard.drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
